// File: rtl/bf16_stream_packer.sv
// Packs LANES consecutive bf16 values from the gelu result stream into wide words,
// buffers them in a first-word-fall-through FIFO and emits them as a framed stream.
module bf16_stream_packer #(
    parameter int LANES      = 4,
    parameter int FRAME_LEN  = 49152,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_tvalid,
    input  logic [31:0]           s_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [16*LANES-1:0]   m_tdata,
    output logic [LANES-1:0]      m_tkeep,
    output logic                  m_tlast,
    output logic                  frame_done,
    output logic                  overflow
);
    localparam int DW   = 16 * LANES;
    localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int EW   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int ENTW = DW + LANES + 1;

    localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);
    localparam logic [EW-1:0] ELEM_LAST = EW'(FRAME_LEN - 1);
    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(FIFO_DEPTH);

    logic [LW-1:0]   lane_cnt_q, lane_cnt_d;
    logic [EW-1:0]   elem_cnt_q, elem_cnt_d;
    logic [DW-1:0]   pack_q, pack_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic            overflow_q, frame_done_q;
    logic [ENTW-1:0] mem_q [FIFO_DEPTH];

    logic [15:0]     lane_data_s;
    logic [DW-1:0]   word_s;
    logic [LANES-1:0] keep_s;
    logic            word_end_s, last_s;
    logic            push_req_s, push_s, pop_s, full_s, m_tvalid_s;
    logic [ENTW-1:0] head_s;
    logic            unused_s;

    assign unused_s = ^s_tdata[15:0];

    // Assemble the word being completed and the next pack/counter state.
    always_comb begin
        lane_data_s = s_tdata[31:16];
        word_end_s  = (lane_cnt_q == LANE_LAST) || (elem_cnt_q == ELEM_LAST);
        last_s      = (elem_cnt_q == ELEM_LAST);
        word_s      = pack_q;
        keep_s      = {LANES{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            if (lane_cnt_q == LW'(k)) begin
                word_s[16*k +: 16] = lane_data_s;
            end else begin
                word_s[16*k +: 16] = pack_q[16*k +: 16];
            end
            keep_s[k] = (LW'(k) <= lane_cnt_q) ? 1'b1 : 1'b0;
        end

        lane_cnt_d = lane_cnt_q;
        elem_cnt_d = elem_cnt_q;
        pack_d     = pack_q;
        if (s_tvalid) begin
            if (word_end_s) begin
                lane_cnt_d = {LW{1'b0}};
                pack_d     = {DW{1'b0}};
            end else begin
                lane_cnt_d = lane_cnt_q + LW'(1);
                pack_d     = word_s;
            end
            elem_cnt_d = last_s ? {EW{1'b0}} : (elem_cnt_q + EW'(1));
        end else begin
            lane_cnt_d = lane_cnt_q;
        end
    end

    // FIFO handshake; a pop in the same cycle frees the slot for a push into a full FIFO.
    always_comb begin
        head_s     = mem_q[rd_ptr_q];
        m_tvalid_s = (count_q != {(AW + 1){1'b0}});
        full_s     = (count_q == DEPTH_W);
        pop_s      = m_tvalid_s & m_tready;
        push_req_s = s_tvalid & word_end_s;
        push_s     = push_req_s & (~full_s | pop_s);
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state and sticky status.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_cnt_q   <= {LW{1'b0}};
            elem_cnt_q   <= {EW{1'b0}};
            pack_q       <= {DW{1'b0}};
            wr_ptr_q     <= {AW{1'b0}};
            rd_ptr_q     <= {AW{1'b0}};
            count_q      <= {(AW + 1){1'b0}};
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            lane_cnt_q   <= lane_cnt_d;
            elem_cnt_q   <= elem_cnt_d;
            pack_q       <= pack_d;
            count_q      <= count_d;
            wr_ptr_q     <= push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
            rd_ptr_q     <= pop_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
            overflow_q   <= overflow_q | (push_req_s & ~push_s);
            frame_done_q <= pop_s & head_s[ENTW-1];
        end
    end

    // FIFO storage; contents are meaningless while the occupancy is zero.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {last_s, keep_s, word_s};
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign m_tvalid   = m_tvalid_s;
    assign m_tdata    = m_tvalid_s ? head_s[DW-1:0] : {DW{1'b0}};
    assign m_tkeep    = m_tvalid_s ? head_s[DW +: LANES] : {LANES{1'b0}};
    assign m_tlast    = m_tvalid_s ? head_s[ENTW-1] : 1'b0;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_bf16_stream_packer.sv
// Drives a default-parameter packer and a short-frame, shallow-FIFO packer with shared
// stimulus and compares both against a queue-based model of the packing rules.
module tb_bf16_stream_packer;
    logic        clk = 1'b0;
    logic        rst_n, s_tvalid, m_tready;
    logic [31:0] s_tdata;

    logic        m_tvalid_a, m_tlast_a, frame_done_a, overflow_a;
    logic [63:0] m_tdata_a;
    logic [3:0]  m_tkeep_a;
    logic        m_tvalid_b, m_tlast_b, frame_done_b, overflow_b;
    logic [63:0] m_tdata_b;
    logic [3:0]  m_tkeep_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bf16_stream_packer dut_a (
        .clk(clk), .rst_n(rst_n), .s_tvalid(s_tvalid), .s_tdata(s_tdata),
        .m_tvalid(m_tvalid_a), .m_tready(m_tready), .m_tdata(m_tdata_a),
        .m_tkeep(m_tkeep_a), .m_tlast(m_tlast_a), .frame_done(frame_done_a),
        .overflow(overflow_a)
    );

    bf16_stream_packer #(.LANES(4), .FRAME_LEN(6), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_tvalid(s_tvalid), .s_tdata(s_tdata),
        .m_tvalid(m_tvalid_b), .m_tready(m_tready), .m_tdata(m_tdata_b),
        .m_tkeep(m_tkeep_b), .m_tlast(m_tlast_b), .frame_done(frame_done_b),
        .overflow(overflow_b)
    );

    // Model state per instance: 0 = default parameters, 1 = FRAME_LEN 6 / depth 4.
    int          flen [2] = '{49152, 6};
    int          dep  [2] = '{16, 4};
    int          ecnt [2];
    int          ccnt [2];
    logic [63:0] cdata [2];
    logic        ovf [2];
    logic        fd [2];
    logic [68:0] fq [2][$];

    task automatic chk_eq(input string tag, input logic [69:0] got, input logic [69:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_step(input int i, input logic v, input logic [31:0] d,
                              input logic r, input logic rn);
        logic [68:0] w;
        logic [3:0]  keep;
        if (!rn) begin
            ecnt[i] = 0; ccnt[i] = 0; cdata[i] = 64'h0; ovf[i] = 1'b0; fd[i] = 1'b0;
            fq[i].delete();
            return;
        end
        fd[i] = 1'b0;
        if (fq[i].size() > 0 && r) begin
            w = fq[i].pop_front();
            fd[i] = w[68];
        end
        if (v) begin
            cdata[i][16*ccnt[i] +: 16] = d[31:16];
            ccnt[i]++;
            ecnt[i]++;
            if (ccnt[i] == 4 || ecnt[i] == flen[i]) begin
                keep = 4'((1 << ccnt[i]) - 1);
                w = {(ecnt[i] == flen[i]), keep, cdata[i]};
                if (fq[i].size() < dep[i]) fq[i].push_back(w);
                else ovf[i] = 1'b1;
                ccnt[i] = 0;
                cdata[i] = 64'h0;
                if (ecnt[i] == flen[i]) ecnt[i] = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic [69:0] exp_a, exp_b;
        exp_a = (fq[0].size() > 0) ? {1'b1, fq[0][0]} : 70'h0;
        exp_b = (fq[1].size() > 0) ? {1'b1, fq[1][0]} : 70'h0;
        chk_eq("a_out", {m_tvalid_a, m_tlast_a, m_tkeep_a, m_tdata_a}, exp_a);
        chk_eq("b_out", {m_tvalid_b, m_tlast_b, m_tkeep_b, m_tdata_b}, exp_b);
        chk_eq("a_ovf", 70'(overflow_a), 70'(ovf[0]));
        chk_eq("b_ovf", 70'(overflow_b), 70'(ovf[1]));
        chk_eq("a_fdone", 70'(frame_done_a), 70'(fd[0]));
        chk_eq("b_fdone", 70'(frame_done_b), 70'(fd[1]));
    endtask

    task automatic cyc(input logic v, input logic [31:0] d, input logic r, input logic rn);
        rst_n = rn; s_tvalid = v; s_tdata = d; m_tready = r;
        @(posedge clk);
        model_step(0, v, d, r, rn);
        model_step(1, v, d, r, rn);
        #1;
        compare_all();
    endtask

    task automatic feed(input int n, input logic r);
        for (int k = 0; k < n; k++) cyc(1'b1, $urandom, r, 1'b1);
    endtask

    task automatic idle(input int n, input logic r);
        for (int k = 0; k < n; k++) cyc(1'b0, $urandom, r, 1'b1);
    endtask

    initial begin
        logic [15:0] hv;
        rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = 32'h0; m_tready = 1'b0;
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        chk_eq("rst_state_a", {m_tvalid_a, m_tlast_a, m_tkeep_a, m_tdata_a}, 70'h0);

        // Contiguous ramp with ready held high.
        for (int i = 0; i < 8; i++) begin
            hv = 16'h3F80 + 16'(i);
            cyc(1'b1, {hv, 16'($urandom)}, 1'b1, 1'b1);
            if (i == 2) chk_eq("ramp_lat_a", 70'(m_tvalid_a), 70'h0);
            if (i == 3) chk_eq("ramp_w0_a", {m_tvalid_a, m_tlast_a, m_tkeep_a, m_tdata_a},
                               {2'b10, 4'hF, 64'h3F833F823F813F80});
            if (i == 5) chk_eq("frame_w1_b", {m_tvalid_b, m_tlast_b, m_tkeep_b, m_tdata_b},
                               {2'b11, 4'h3, 64'h000000003F853F84});
            if (i == 6) chk_eq("frame_done_b", 70'(frame_done_b), 70'h1);
            if (i == 7) chk_eq("ramp_w1_a", {m_tvalid_a, m_tlast_a, m_tkeep_a, m_tdata_a},
                               {2'b10, 4'hF, 64'h3F873F863F853F84});
        end
        idle(4, 1'b1);

        // Fill the shallow FIFO, then push and pop on the same edge.
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        feed(15, 1'b0);
        cyc(1'b1, $urandom, 1'b1, 1'b1);
        idle(1, 1'b0);
        chk_eq("fullpop_ovf_b", 70'(overflow_b), 70'h0);
        idle(8, 1'b1);

        // Stalled output until the shallow FIFO drops a word.
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        feed(20, 1'b0);
        chk_eq("stall_ovf_b", 70'(overflow_b), 70'h1);
        chk_eq("stall_ovf_a", 70'(overflow_a), 70'h0);
        idle(3, 1'b0);
        idle(20, 1'b1);

        // Gapped input: one element every third cycle.
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 36; i++) cyc((i % 3) == 0, $urandom, 1'b1, 1'b1);
        idle(4, 1'b1);

        // Reset with a partial word and a buffered word.
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        feed(6, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        chk_eq("midrst_valid_a", 70'(m_tvalid_a), 70'h0);
        feed(4, 1'b1);
        idle(4, 1'b1);

        // Random traffic and backpressure with occasional resets.
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 4) != 0, $urandom, ($urandom % 2) == 0, ($urandom % 600) != 0);
        end
        idle(20, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
